// File: rtl/lsu_if.sv
// Core-request and data-memory signals of the load/store unit.
// master = the LSU itself; slave = core plus data memory around it.
interface lsu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             we;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    input  start, we, funct3, addr, wdata, mem_rdata, mem_ack,
    output busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output start, we, funct3, addr, wdata, mem_rdata, mem_ack,
    input  busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: byte-lane steering, load extension and req/ack memory access.
// Define LSU_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module lsu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  if (WIDTH != 32 || TIMEOUT == 0) begin : g_cfg_check
    $error("lsu: only WIDTH=32 and TIMEOUT>0 are supported");
  end

  logic [1:0]       state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             legal;
  logic [3:0]       be_req;
  logic [WIDTH-1:0] wdata_req;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] load_val;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
`endif

  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~bus.addr[0];
      3'b010:  legal = (bus.addr[1:0] == 2'b00);
      3'b100:  legal = ~bus.we;
      3'b101:  legal = ~bus.we & ~bus.addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Lane pattern is computed for loads too so memory sees the accessed bytes.
  always_comb begin
    be_req    = 4'b1111;
    wdata_req = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        be_req    = 4'b0001 << bus.addr[1:0];
        wdata_req = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_req    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_req = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   load_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          f3_d        = bus.funct3;
          off_d       = bus.addr[1:0];
          mem_we_d    = bus.we;
          mem_addr_d  = {bus.addr[WIDTH-1:2], 2'b00};
          mem_be_d    = be_req;
          mem_wdata_d = wdata_req;
          err_d       = ~legal;
          if (legal) begin
            state_d = ACCESS;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = RESP;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d = RESP;
          if (!mem_we_q) rdata_d = load_val;
        end
`ifdef LSU_TIMEOUT_EN
        // An ack on the final cycle takes priority over the abort.
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == RESP);
  assign bus.err       = (state_q == RESP) & err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == ACCESS);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses against
// an arithmetic reference model of RV32I load/store semantics.
module tb_lsu;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  lsu_if #(.WIDTH(32)) bus ();

  lsu #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic bit m_legal(input bit w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned n = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
    if (w && f3[2]) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n = 1 << f3[1:0];
    int unsigned base = (a % 4) / n * n;
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned n = 1 << f3[1:0];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % n)));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    int unsigned n = 1 << f3[1:0];
    longint v = (64'(w) >> (8 * ((a % 4) / n * n))) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // delay < 0 means memory never acknowledges.
  task automatic run_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] word, input int delay,
                            input bit poke, input string tag);
    bit lg, fin, eerr;
    int edges, reqs, e_edges, e_reqs;
    logic [31:0] er;
    lg = m_legal(w, f3, a);
    if (!lg) begin
      eerr = 1'b1; er = '0; e_edges = 1; e_reqs = 0;
    end else if (delay < 0) begin
      eerr = 1'b1; er = exp_rdata; e_edges = TO + 1; e_reqs = TO;
    end else begin
      eerr = 1'b0; er = w ? exp_rdata : m_load(f3, a, word);
      e_edges = delay + 2; e_reqs = delay + 1;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    bus.mem_ack = 1'b0;
    edges = 0; reqs = 0; fin = 1'b0;
    for (int t = 0; t < 100 && !fin; t++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.start = poke;
      if (poke) begin
        bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
      end
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        reqs++;
        checks++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
            {w, m_be(f3, a), a & ~32'd3, m_wdata(f3, d)}) begin
          errors++;
          $display("FAIL %s mem_bus: got we=%b be=%b addr=%h wdata=%h, exp we=%b be=%b addr=%h wdata=%h",
                   tag, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                   w, m_be(f3, a), a & ~32'd3, m_wdata(f3, d));
        end
        if (delay >= 0 && reqs == delay + 1) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = word;
        end
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b exp 1 at edge %0d", tag, bus.busy, edges);
      end
      if (bus.done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if ({edges, reqs} !== {e_edges, e_reqs}) begin
          errors++;
          $display("FAIL %s latency: got done_edge=%0d reqs=%0d, exp done_edge=%0d reqs=%0d",
                   tag, edges, reqs, e_edges, e_reqs);
        end
        checks++;
        if ({bus.err, bus.rdata} !== {eerr, er}) begin
          errors++;
          $display("FAIL %s response: got err=%b rdata=%h, exp err=%b rdata=%h",
                   tag, bus.err, bus.rdata, eerr, er);
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s no_done: got no done in 100 cycles, exp done", tag);
    end
    exp_rdata = er;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.mem_req, bus.rdata} !== {3'b000, exp_rdata}) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b done=%b req=%b rdata=%h, exp 0 0 0 %h",
               tag, bus.busy, bus.done, bus.mem_req, bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    exp_rdata = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.busy, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.rdata, bus.mem_addr,
           bus.mem_wdata, bus.mem_be} !== '0) begin
        errors++;
        $display("FAIL reset_state: got busy=%b done=%b err=%b req=%b we=%b rdata=%h addr=%h wdata=%h be=%b, exp all 0",
                 bus.busy, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.rdata,
                 bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, "lw");
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_const: got %h exp deadbeef", bus.rdata);
    end
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0, "lb");
    checks++;
    if (bus.rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_const: got %h exp ffffff80", bus.rdata);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0, "lbu");
    checks++;
    if (bus.rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_const: got %h exp 00000080", bus.rdata);
    end
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0, 1'b0, "lh_hi");
    run_access(1'b0, 3'b101, 32'h100, 32'h0, 32'h8001_F00F, 2, 1'b0, "lhu_lo");
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 1'b0, "sh");
    run_access(1'b1, 3'b000, 32'h201, 32'h0000_005A, 32'h0, 0, 1'b0, "sb");
    run_access(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0, 1, 1'b0, "sw");
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0, 1'b0, "lw_misaligned");
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL err_rdata_const: got %h exp 00000000", bus.rdata);
    end
    run_access(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 1'b0, "store_bu");
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0, "f3_011");
    run_access(1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 1'b0, "lh_odd");
  endtask

  task automatic test_busy_ignore;
    run_access(1'b0, 3'b010, 32'h340, 32'h0, 32'h0BAD_CAFE, 2, 1'b1, "poke_load");
    run_access(1'b1, 3'b000, 32'h343, 32'h77, 32'h0, 0, 1'b1, "poke_store");
    run_access(1'b0, 3'b110, 32'h340, 32'h0, 32'h0, 0, 1'b1, "poke_illegal");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.busy} !== 2'b00) begin
        errors++;
        $display("FAIL poke_idle: got req=%b busy=%b exp 0 0", bus.mem_req, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h1357_9BDF, 0, 1'b0, "pre_reset_load");
    @(negedge clk);
    bus.start = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h440;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_req: got %b exp 1", bus.mem_req);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    checks++;
    if ({bus.mem_req, bus.busy, bus.done, bus.err, bus.mem_we, bus.rdata, bus.mem_addr,
         bus.mem_be, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b busy=%b done=%b err=%b rdata=%h addr=%h be=%b, exp all 0",
               bus.mem_req, bus.busy, bus.done, bus.err, bus.rdata, bus.mem_addr, bus.mem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.busy, bus.done, bus.rdata} !== {3'b000, 32'h0}) begin
        errors++;
        $display("FAIL stale_ack: got req=%b busy=%b done=%b rdata=%h exp 0 0 0 0",
                 bus.mem_req, bus.busy, bus.done, bus.rdata);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_random;
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'd3 | 32'($urandom_range(0, 1) * 2 * f3[0]);
      if (f3[1:0] == 2'b00) a = $urandom;
      run_access(w, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h2468_ACE0, 0, 1'b0, "to_pre");
    run_access(1'b0, 3'b010, 32'h504, 32'h0, 32'h0, -1, 1'b0, "to_load");
    run_access(1'b1, 3'b010, 32'h508, 32'h1, 32'h0, -1, 1'b1, "to_store");
    run_access(1'b0, 3'b000, 32'h50A, 32'h0, 32'h00C3_0000, TO - 1, 1'b0, "to_ack_last");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as an effective byte address and the rs2 value as store data.
- Performs RV32I LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide data memory using a req/ack handshake.
- Returns the extended load data, or an error, to the writeback stage.
- Stalls the core via busy while an access is in flight.

Parameters:
- WIDTH, 32: address and data width. Only 32 is supported.
- TIMEOUT, 16: number of ACCESS cycles without mem_ack before the access is aborted with err. Active only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  size/sign select: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  WIDTH  effective byte address (ALU output).
- wdata  in  WIDTH  store data (rs2).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  WIDTH  extended load result; valid with done and held until the next accepted start.
- err  out  1  valid with done: misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  WIDTH  word address: {addr[WIDTH-1:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_rdata  in  WIDTH  memory read word.
- mem_ack  in  1  memory completion; qualifies mem_rdata.

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately, including mid-access:
  - state = IDLE.
  - busy, done, err, mem_req, mem_we = 0.
  - rdata, mem_addr, mem_wdata = 0; mem_be = 0000.
  - Timeout counter = 0.
  - A pending memory transaction is abandoned; any mem_ack after reset is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On start=1, latch we, funct3, addr[1:0], and drive mem_addr, mem_be, mem_wdata, mem_we from the request.
  - Legality check at acceptance:
    - h/hu requires addr[0]=0; w requires addr[1:0]=00.
    - funct3 011, 110, 111 are illegal.
    - funct3 100 or 101 with we=1 is illegal.
  - Illegal request -> RESP with err=1; mem_req is never asserted.
  - Legal request -> ACCESS.
- ACCESS:
  - mem_req=1; mem_addr, mem_be, mem_we, mem_wdata stable until ack.
  - On mem_ack=1 (may occur in the first ACCESS cycle): mem_req drops next cycle; for loads, rdata is registered from the extracted mem_rdata; -> RESP.
- RESP:
  - done=1 for exactly one cycle; err=1 if the request failed; -> IDLE.
  - busy is high in ACCESS and RESP.
- start while busy is ignored; no queuing.
- start in the same cycle as the done pulse is ignored. The earliest a new request is accepted is the first IDLE cycle.
- Latency: start accepted at cycle 0, mem_req from cycle 1, ack at cycle k>=1 -> done at cycle k+1. Zero-wait memory gives done at cycle 2. Illegal request gives done at cycle 1.
- Lane rules, with o = addr[1:0]:
  - b/bu: mem_be = 0001<<o; mem_wdata = {4{wdata[7:0]}}.
  - h/hu: mem_be = o[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - w: mem_be = 1111; mem_wdata = wdata.
  - Loads drive the same mem_be pattern.
- Load extraction:
  - Byte = mem_rdata[8*o +: 8]; half = mem_rdata[16*o[1] +: 16].
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- Stores: rdata holds its previous value.
- Error responses: rdata = 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT, mem_req drops and the FSM goes to RESP with err=1, and rdata is unchanged. An ack arriving in the same cycle the count reaches TIMEOUT wins: the access completes normally.
- Undefined: no counter; ACCESS waits indefinitely; err only flags illegal requests.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ack in the first ACCESS cycle -> mem_addr=0x100, mem_be=1111, done at cycle 2, rdata=0xDEADBEEF, err=0.
- LB addr=0x103, rdata word 0x80FF_0000 -> mem_be=1000, rdata=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack delayed 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held 3 cycles, done one cycle after ack.
- LW addr=0x101 -> no mem_req, done at cycle 1 with err=1, rdata=0; SB-style funct3=100 with we=1 -> err=1.
- start pulsed during ACCESS and during done -> ignored, no second mem_req; rst_n low mid-ACCESS -> mem_req=0, busy=0 immediately, a later ack ignored.
- With LSU_TIMEOUT_EN and TIMEOUT=16, ack never asserted -> mem_req drops after 16 ACCESS cycles, done with err=1.
